// File: rtl/detector_nota_if.sv
// detector_nota_if: bundles the tone input and the measurement outputs of
// detector_nota.
//   tone_in      - asynchronous square-wave tone (driven by the source)
//   period       - last measured period in clock cycles
//   note         - 0 = none, 1..8 = do, re, mi, fa, sol, la, si, do alto
//   note_valid   - note is non-zero and the signal is present
//   sample_pulse - one-cycle strobe when period/note update
//   no_signal    - block is idle or has timed out
// Modports: master = tone source / result consumer, slave = detector.
interface detector_nota_if;
    logic        tone_in;
    logic [27:0] period;
    logic [3:0]  note;
    logic        note_valid;
    logic        sample_pulse;
    logic        no_signal;

    modport master (
        output tone_in,
        input  period, note, note_valid, sample_pulse, no_signal
    );

    modport slave (
        input  tone_in,
        output period, note, note_valid, sample_pulse, no_signal
    );
endinterface

// File: rtl/detector_nota.sv
// detector_nota: measures the period of an incoming square-wave tone between
// consecutive rising edges and classifies it as one of eight notes.
// Ports:
//   clock_in - system clock (50 MHz nominal)
//   reset    - asynchronous, active-high reset
//   bus      - detector_nota_if.slave (tone_in in; period, note, note_valid,
//              sample_pulse, no_signal out)
// Pipeline: sync1 -> sync2 -> prev (edge detect) -> capture of cnt into meas
// -> registered classification onto the outputs.
module detector_nota #(
    parameter int unsigned TOL_SHIFT = 6,
    parameter logic [27:0] TIMEOUT   = 28'd400000,
    parameter logic [27:0] P_DO      = 28'd191205,
    parameter logic [27:0] P_RE      = 28'd170265,
    parameter logic [27:0] P_MI      = 28'd151685,
    parameter logic [27:0] P_FA      = 28'd143172,
    parameter logic [27:0] P_SOL     = 28'd127551,
    parameter logic [27:0] P_LA      = 28'd113636,
    parameter logic [27:0] P_SI      = 28'd101239,
    parameter logic [27:0] P_DO_ALTO = 28'd95556
) (
    input logic             clock_in,
    input logic             reset,
    detector_nota_if.slave  bus
);

    // Index i holds the reference period of note code i+1.
    localparam logic [7:0][27:0] REFS = {P_DO_ALTO, P_SI, P_LA, P_SOL,
                                         P_FA, P_MI, P_RE, P_DO};

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t      state, state_next;
    logic        sync1, sync2, prev;
    logic        rise;
    logic [27:0] cnt;
    logic [27:0] meas;
    logic        meas_vld;
    logic        restart, capture, go_idle;
    logic [3:0]  code;

    // Absolute difference taken in whichever order cannot underflow.
    function automatic logic in_window(input logic [27:0] p,
                                       input logic [27:0] refp);
        logic [27:0] d;
        d = (p >= refp) ? (p - refp) : (refp - p);
        return d <= (refp >> TOL_SHIFT);
    endfunction

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= bus.tone_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Only rising edges matter; duty cycle is irrelevant.
    assign rise = sync2 & ~prev;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A rising edge wins over a coincident timeout.
    always_comb begin
        state_next = state;
        restart    = 1'b0;
        capture    = 1'b0;
        go_idle    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = MEASURE;
                    restart    = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    restart = 1'b1;
                    capture = 1'b1;
                end else if (cnt >= TIMEOUT) begin
                    state_next = IDLE;
                    go_idle    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // cnt reads 1 on the cycle after an edge, so it equals the edge-to-edge
    // distance when the next edge arrives. Saturation keeps it from wrapping
    // while idle.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset)               cnt <= '0;
        else if (restart)        cnt <= 28'd1;
        else if (cnt < TIMEOUT)  cnt <= cnt + 28'd1;
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            meas     <= '0;
            meas_vld <= 1'b0;
        end else begin
            meas_vld <= capture;
            if (capture) meas <= cnt;
        end
    end

    // Walk from the highest code down so the lowest matching code is kept.
    always_comb begin
        code = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (in_window(meas, REFS[i])) code = 4'(i + 1);
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            bus.period       <= '0;
            bus.note         <= 4'd0;
            bus.note_valid   <= 1'b0;
            bus.sample_pulse <= 1'b0;
            bus.no_signal    <= 1'b1;
        end else begin
            bus.sample_pulse <= meas_vld;
            if (meas_vld) begin
                bus.period     <= meas;
                bus.note       <= code;
                bus.note_valid <= (code != 4'd0);
                bus.no_signal  <= 1'b0;
            end else if (go_idle) begin
                // period is kept so the last measurement stays readable
                bus.note       <= 4'd0;
                bus.note_valid <= 1'b0;
                bus.no_signal  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_detector_nota.sv
// tb_detector_nota: drives square-wave tones (directed note phases plus a
// randomized run) into detector_nota with shortened reference periods and
// timeout, and checks every output on every cycle against an edge-timestamp
// model, plus literal expectations at the end of each directed phase.
module tb_detector_nota;

    localparam int TMO = 2000;
    localparam int REFS [8] = '{956, 851, 758, 715, 637, 568, 506, 477};

    logic clock_in = 1'b0;
    logic reset    = 1'b1;

    detector_nota_if bus();

    detector_nota #(
        .TOL_SHIFT (6),
        .TIMEOUT   (28'(TMO)),
        .P_DO      (28'd956),
        .P_RE      (28'd851),
        .P_MI      (28'd758),
        .P_FA      (28'd715),
        .P_SOL     (28'd637),
        .P_LA      (28'd568),
        .P_SI      (28'd506),
        .P_DO_ALTO (28'd477)
    ) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clock_in = ~clock_in;

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input int p);
        for (int i = 0; i < 8; i++) begin
            int d;
            d = (p >= REFS[i]) ? p - REFS[i] : REFS[i] - p;
            if (d <= (REFS[i] >> 6)) return i + 1;
        end
        return 0;
    endfunction

    // ---------------- reference model ----------------
    // Works on the tone as sampled at each posedge: a rising edge sampled at
    // cycle k shows on the outputs after cycle k+3; a missing edge TMO cycles
    // after the last one shows as idle after cycle k+2.
    typedef struct {
        int due;
        bit smp;
        int per;
        int nt;
    } ev_t;

    ev_t evq[$];
    int  cyc    = 0;
    int  last_k = 0;
    bit  last_s = 1'b0;
    bit  armed  = 1'b0;
    bit  m_s;
    int  e_period = 0;
    int  e_note   = 0;
    bit  e_valid  = 1'b0;
    bit  e_pulse  = 1'b0;
    bit  e_nosig  = 1'b1;

    initial begin
        forever begin
            @(posedge clock_in);
            if (reset) begin
                evq.delete();
                armed    = 1'b0;
                last_s   = 1'b0;
                e_period = 0;
                e_note   = 0;
                e_valid  = 1'b0;
                e_pulse  = 1'b0;
                e_nosig  = 1'b1;
            end else begin
                m_s = bus.tone_in;
                cyc++;
                e_pulse = 1'b0;
                if (m_s && !last_s) begin
                    if (armed) evq.push_back('{cyc + 3, 1'b1, cyc - last_k, classify(cyc - last_k)});
                    armed  = 1'b1;
                    last_k = cyc;
                end else if (armed && (cyc - last_k == TMO)) begin
                    armed = 1'b0;
                    evq.push_back('{cyc + 2, 1'b0, 0, 0});
                end
                last_s = m_s;
                while (evq.size() > 0 && evq[0].due == cyc) begin
                    if (evq[0].smp) begin
                        e_period = evq[0].per;
                        e_note   = evq[0].nt;
                        e_valid  = (evq[0].nt != 0);
                        e_nosig  = 1'b0;
                        e_pulse  = 1'b1;
                    end else begin
                        e_note  = 0;
                        e_valid = 1'b0;
                        e_nosig = 1'b1;
                    end
                    void'(evq.pop_front());
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            logic [27:0] xp;
            logic [3:0]  xn;
            logic        xv, xs, xi;
            @(negedge clock_in);
            if (reset) begin
                xp = '0; xn = '0; xv = 1'b0; xs = 1'b0; xi = 1'b1;
            end else begin
                xp = 28'(e_period); xn = 4'(e_note); xv = e_valid; xs = e_pulse; xi = e_nosig;
            end
            checks++;
            if (bus.period !== xp || bus.note !== xn || bus.note_valid !== xv ||
                bus.sample_pulse !== xs || bus.no_signal !== xi) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t actual p=%0d n=%0d v=%0b s=%0b ns=%0b required p=%0d n=%0d v=%0b s=%0b ns=%0b",
                         $time, bus.period, bus.note, bus.note_valid, bus.sample_pulse, bus.no_signal,
                         xp, xn, xv, xs, xi);
            end
            if (bus.sample_pulse === 1'b1) strobes++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tone(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            bus.tone_in = 1'b1;
            repeat (hi) @(negedge clock_in);
            bus.tone_in = 1'b0;
            repeat (lo) @(negedge clock_in);
        end
    endtask

    task automatic quiet(input int n);
        bus.tone_in = 1'b0;
        repeat (n) @(negedge clock_in);
    endtask

    initial begin
        int s0;
        bus.tone_in = 1'b0;

        // reset held while the tone toggles
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_in);
            bus.tone_in = ~bus.tone_in;
            repeat (2) @(negedge clock_in);
        end
        chk("reset_period", bus.period, 0);
        chk("reset_nosig", bus.no_signal, 1);
        bus.tone_in = 1'b0;
        @(negedge clock_in);
        #2 reset = 1'b0;

        // do: first edge only arms, then 3 strobes of 956
        s0 = strobes;
        tone(478, 478, 1);
        chk("first_edge_no_strobe", strobes - s0, 0);
        tone(478, 478, 3);
        chk("do_strobes", strobes - s0, 3);
        chk("do_period", bus.period, 956);
        chk("do_note", bus.note, 1);
        chk("do_valid", bus.note_valid, 1);
        chk("do_nosig", bus.no_signal, 0);

        // la just inside (+7) and just outside (+9) the +/-8 window
        tone(287, 288, 3);
        chk("la_in_period", bus.period, 575);
        chk("la_in_note", bus.note, 6);
        tone(288, 289, 3);
        chk("la_out_period", bus.period, 577);
        chk("la_out_note", bus.note, 0);
        chk("la_out_valid", bus.note_valid, 0);
        chk("la_out_nosig", bus.no_signal, 0);

        // sol then si mid-stream
        tone(318, 319, 3);
        chk("sol_note", bus.note, 5);
        s0 = strobes;
        tone(253, 253, 3);
        chk("si_strobes", strobes - s0, 3);
        chk("si_note", bus.note, 7);
        chk("si_period", bus.period, 506);

        // mi then silence: timeout keeps the period
        s0 = strobes;
        tone(379, 379, 3);
        quiet(2500);
        chk("mi_strobes", strobes - s0, 3);
        chk("tmo_nosig", bus.no_signal, 1);
        chk("tmo_note", bus.note, 0);
        chk("tmo_valid", bus.note_valid, 0);
        chk("tmo_period", bus.period, 758);

        // two edges rearm and give one sample
        s0 = strobes;
        tone(379, 379, 2);
        chk("rearm_strobes", strobes - s0, 1);
        chk("rearm_note", bus.note, 3);
        chk("rearm_nosig", bus.no_signal, 0);

        // fa with reset in the middle of a period
        tone(357, 358, 2);
        bus.tone_in = 1'b1;
        repeat (100) @(negedge clock_in);
        #2 reset = 1'b1;
        #1;
        chk("areset_period", bus.period, 0);
        chk("areset_note", bus.note, 0);
        chk("areset_valid", bus.note_valid, 0);
        chk("areset_nosig", bus.no_signal, 1);
        for (int i = 0; i < 5; i++) begin
            bus.tone_in = ~bus.tone_in;
            repeat (7) @(negedge clock_in);
        end
        bus.tone_in = 1'b0;
        @(negedge clock_in);
        #2 reset = 1'b0;
        s0 = strobes;
        tone(357, 358, 3);
        chk("fa_strobes", strobes - s0, 2);
        chk("fa_note", bus.note, 4);
        chk("fa_period", bus.period, 715);
        quiet(2500);

        // edge exactly at the timeout count, then one cycle past it
        tone(1000, 1000, 1);
        tone(1000, 1001, 1);
        chk("edge_at_tmo_period", bus.period, TMO);
        chk("edge_at_tmo_nosig", bus.no_signal, 0);
        tone(250, 249, 1);
        chk("past_tmo_nosig", bus.no_signal, 1);
        chk("past_tmo_period", bus.period, TMO);
        tone(250, 249, 1);
        chk("si_low_edge_note", bus.note, 7);
        chk("si_low_edge_period", bus.period, 499);
        tone(235, 234, 1);

        // randomized notes around the references
        for (int i = 0; i < 30; i++) begin
            int r, p;
            r = int'($urandom_range(0, 7));
            p = REFS[r] + int'($urandom_range(0, 40)) - 20;
            tone(p / 2, p - p / 2, 1);
        end
        quiet(2500);
        chk("end_nosig", bus.no_signal, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
